data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters: none; geometry is fixed by shared constants: 8 lines, 4-byte blocks, 3-bit tag, 3-bit index, 2-bit offset.
REQ-002 The clock and reset ports SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 READ  in  1  CPU load request, held until BUSYWAIT is low.
REQ-006 WRITE  in  1  CPU store request, held until BUSYWAIT is low.
REQ-007 ADDRESS  in  8  CPU byte address {tag[7:5], index[4:2], offset[1:0]}.
REQ-008 WRITEDATA  in  8  CPU store byte.
REQ-009 READDATA  out  8  CPU load byte.
REQ-010 BUSYWAIT  out  1  CPU stall; while high the CPU holds PC and request.
REQ-011 MEM_READ  out  1  block fetch request to data memory.
REQ-012 MEM_WRITE  out  1  block write-back request to data memory.
REQ-013 MEM_ADDRESS  out  6  memory block address {tag, index}.
REQ-014 MEM_WRITEDATA  out  32  victim block, byte 0 in bits [7:0].
REQ-015 MEM_READDATA  in  32  fetched block, byte 0 in bits [7:0].
REQ-016 MEM_BUSYWAIT  in  1  memory busy; high while a MEM_READ or MEM_WRITE transaction is in progress.

Function
REQ-017 Organisation: direct-mapped, write-back, write-allocate; per line: valid bit, dirty bit, 3-bit tag, 32-bit data.
REQ-018 Hit = READ or WRITE asserted, valid[index] = 1, and tag[index] = ADDRESS[7:5]; hit detection and READDATA byte selection SHALL be combinational.
REQ-019 Read hit: READDATA = selected byte and BUSYWAIT = 0 in the same cycle, with zero added cycles.
REQ-020 Write hit: BUSYWAIT = 0 in the same cycle; byte at offset updated and dirty set at the next rising CLK.
REQ-021 Idle (no request): BUSYWAIT = 0; READDATA holds its last value.
REQ-022 FSM states: IDLE, WRITEBACK, FETCH.
REQ-023 IDLE: on a miss with a clean or invalid victim, go to FETCH; on a miss with a dirty victim, go to WRITEBACK. BUSYWAIT = 1 from the miss cycle until the request hits.
REQ-024 WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {tag[index], index}, MEM_WRITEDATA = line data; when MEM_BUSYWAIT = 0, go to FETCH.
REQ-025 FETCH: MEM_READ = 1, MEM_ADDRESS = ADDRESS[7:2]; when MEM_BUSYWAIT = 0, on that edge write MEM_READDATA into the line, set tag, set valid = 1, clear dirty, and go to IDLE.
REQ-026 After a fill, the held request hits in IDLE on the next cycle (REQ-019/020 apply); miss latency = write-back time + fetch time + 1 cycle.
REQ-027 MEM_READ and MEM_WRITE SHALL never both be high.
REQ-028 MEM_READ and MEM_WRITE SHALL be 0 in IDLE.
REQ-029 READ and WRITE asserted together: treated as WRITE.
REQ-030 A request that drops while the FSM is not in IDLE: the current memory transaction completes, then the FSM returns to IDLE; no CPU-side update is made.

Reset
REQ-031 RESET low SHALL immediately set: all valid = 0, all dirty = 0, state = IDLE, MEM_READ = 0, MEM_WRITE = 0, BUSYWAIT = 0, READDATA = 0.
REQ-032 Reset mid-miss SHALL abandon the memory transaction without corrupting any line; tags and data need not be cleared.

Structure
REQ-033 A shared package SHALL hold the tag/index/offset widths, the line count, and the FSM state encoding.
REQ-034 Sub-module: cache_line_array (valid/dirty/tag/data storage with asynchronous clear of valid and dirty); the FSM and hit logic live in data_cache.

Verification
REQ-035 Reset, then READ 0x14 with memory block 0x05 = 0xDDCCBBAA, 5-cycle memory -> MEM_READ with MEM_ADDRESS 0x05, no MEM_WRITE, then READDATA = 0xAA and BUSYWAIT low.
REQ-036 WRITE 0x16 = 0x3C after the fill -> zero-stall hit; next READ 0x16 returns 0x3C; dirty[5] = 1.
REQ-037 READ 0x34 (same index, tag 1) with line 5 dirty -> MEM_WRITE at 0x05 with 0xDD3CBBAA, then MEM_READ at 0x0D, then hit.
REQ-038 RESET low during FETCH -> MEM_READ drops the same cycle; the following READ 0x14 misses.
REQ-039 READ and WRITE together at 0x00 with 0x55 -> behaves as a write; a later READ 0x00 returns 0x55.
REQ-040 Bench assertion on every cycle -> MEM_READ and MEM_WRITE never high together; BUSYWAIT never low on a miss.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped, write-back data cache.
// Byte address layout is {tag, index, offset}; memory block address is {tag, index}.
package data_cache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int LINES      = 8;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;
    localparam int BLOCK_W    = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } addr_t;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache; the cache uses the slave view,
// the CPU/memory environment uses the master view.
//
// Handshake: the CPU asserts read/write with address/writedata and holds them
// unchanged while busywait is high; the request is accepted in the cycle where
// busywait is low. Toward memory the cache holds mem_read/mem_write with
// mem_address/mem_writedata until it samples mem_busywait low at a rising edge.
interface data_cache_if;
    import data_cache_pkg::*;

    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [7:0]            writedata;
    logic [7:0]            readdata;
    logic                  busywait;

    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_writedata;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

endinterface

// File: rtl/data_cache_line_array.sv
// Line storage: valid/dirty bits clear asynchronously on reset; tag and data are
// not reset, since an invalid line never produces a hit.
module cache_line_array
    import data_cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] index,
    output logic               valid,
    output logic               dirty,
    output logic [TAG_W-1:0]   tag,
    output logic [BLOCK_W-1:0] data,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data,
    input  logic               byte_en,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [7:0]         byte_data
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (byte_en) begin
            data_q[index][{byte_offset, 3'b000} +: 8] <= byte_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: combinational hit path,
// IDLE/WRITEBACK/FETCH miss FSM, line storage in cache_line_array.
module data_cache
    import data_cache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    data_cache_if.slave bus,
    output state_t      state
);

    addr_t                 cpu_addr;
    logic                  req;
    logic                  hit;
    logic                  read_hit;
    logic                  write_hit;
    logic                  miss_start;
    state_t                state_q;
    state_t                state_d;
    logic [MEM_ADDR_W-1:0] miss_block;
    logic [INDEX_W-1:0]    line_index;
    logic                  line_valid;
    logic                  line_dirty;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic [7:0]            sel_byte;
    logic [7:0]            readdata_q;
    logic                  busy;
    logic                  mem_read;
    logic                  mem_write;
    logic                  fill_en;
    logic [MEM_ADDR_W-1:0] mem_address;

    assign cpu_addr = addr_t'(bus.address);
    assign req      = bus.read | bus.write;

    // Outside IDLE the line of the latched miss is addressed, so a wandering CPU
    // address cannot redirect a write-back or fill to another line.
    assign line_index = (state_q == IDLE) ? cpu_addr.index : miss_block[INDEX_W-1:0];

    assign hit        = req && line_valid && (line_tag == cpu_addr.tag) && (state_q == IDLE);
    assign write_hit  = hit && bus.write;
    assign read_hit   = hit && !bus.write;
    assign miss_start = (state_q == IDLE) && req && !hit;
    assign sel_byte   = line_data[{cpu_addr.offset, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            readdata_q <= '0;
            miss_block <= '0;
        end else begin
            state_q <= state_d;
            if (read_hit) begin
                readdata_q <= sel_byte;
            end
            if (miss_start) begin
                miss_block <= {cpu_addr.tag, cpu_addr.index};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        fill_en     = 1'b0;
        mem_address = miss_block;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    busy    = 1'b1;
                    state_d = (line_valid && line_dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_address = {line_tag, miss_block[INDEX_W-1:0]};
                if (!bus.mem_busywait) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!bus.mem_busywait) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    cache_line_array u_lines (
        .clk         (clk),
        .reset       (reset),
        .index       (line_index),
        .valid       (line_valid),
        .dirty       (line_dirty),
        .tag         (line_tag),
        .data        (line_data),
        .fill_en     (fill_en),
        .fill_tag    (miss_block[MEM_ADDR_W-1:INDEX_W]),
        .fill_data   (bus.mem_readdata),
        .byte_en     (write_hit),
        .byte_offset (cpu_addr.offset),
        .byte_data   (bus.writedata)
    );

    // Reset gates the stall directly so it drops in the same instant reset asserts.
    assign bus.busywait      = busy & reset;
    assign bus.readdata      = read_hit ? sel_byte : readdata_q;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_address   = mem_address;
    assign bus.mem_writedata = line_data;
    assign state             = state_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized accesses
// against a line-level reference model and a latency-configurable memory model.
module tb_data_cache;
    import data_cache_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_txn_t;

    logic   clk = 1'b0;
    logic   reset;
    state_t state;

    data_cache_if bus ();

    data_cache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .state (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: a request completes after mem_lat cycles in the requesting state.
    logic [31:0] mem_arr  [64];
    logic [31:0] init_mem [64];
    mem_txn_t    mon_q[$];
    int          cnt      = 0;
    int          mem_lat  = 5;
    int          rd_count = 0;
    bit          do_init  = 1'b0;

    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (cnt < mem_lat - 1);
    assign bus.mem_readdata = mem_arr[bus.mem_address];

    always @(posedge clk) begin
        if (!reset) begin
            cnt <= 0;
            if (do_init) begin
                for (int i = 0; i < 64; i++) mem_arr[i] <= init_mem[i];
            end
        end else if (!(bus.mem_read || bus.mem_write)) begin
            cnt <= 0;
        end else if (cnt < mem_lat - 1) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
            if (bus.mem_write) begin
                mem_arr[bus.mem_address] <= bus.mem_writedata;
                mon_q.push_back(mem_txn_t'{1'b1, bus.mem_address, bus.mem_writedata});
            end else begin
                mon_q.push_back(mem_txn_t'{1'b0, bus.mem_address, mem_arr[bus.mem_address]});
                rd_count <= rd_count + 1;
            end
        end
    end

    // Reference model: what each cache line and each memory block should hold.
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] ref_mem [64];
    logic [7:0]  last_rd = 8'h00;
    bit          cur_hit = 1'b0;
    int          rd_start = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        last_rd = 8'h00;
    endtask

    // Per-cycle properties.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
                errors++;
                $display("FAIL mem_exclusive: mem_read=%b mem_write=%b both high", bus.mem_read, bus.mem_write);
            end
            if ((bus.read || bus.write) && !cur_hit && rd_count == rd_start) begin
                checks++;
                if (bus.busywait !== 1'b1) begin
                    errors++;
                    $display("FAIL busywait_on_miss: busywait=%b required 1 before fill", bus.busywait);
                end
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int lat, input string name);
        logic [2:0] t;
        logic [2:0] ix;
        int         o;
        int         exp_stall;
        int         stall;
        int         base;
        bit         hit;
        logic [7:0] exp_rd;
        logic [7:0] obs_rd;
        mem_txn_t   e[$];
        t = addr[7:5];
        ix = addr[4:2];
        o = int'(addr[1:0]);
        exp_stall = 0;
        exp_rd = 8'h00;
        hit = m_valid[ix] && (m_tag[ix] == t);
        if (!hit) begin
            if (m_valid[ix] && m_dirty[ix]) begin
                e.push_back(mem_txn_t'{1'b1, {m_tag[ix], ix}, m_data[ix]});
                ref_mem[{m_tag[ix], ix}] = m_data[ix];
                exp_stall += lat;
            end
            e.push_back(mem_txn_t'{1'b0, {t, ix}, ref_mem[{t, ix}]});
            m_data[ix]  = ref_mem[{t, ix}];
            m_valid[ix] = 1'b1;
            m_dirty[ix] = 1'b0;
            m_tag[ix]   = t;
            exp_stall += lat + 1;
        end
        if (wr) begin
            m_data[ix][o*8 +: 8] = wdata;
            m_dirty[ix] = 1'b1;
        end else begin
            exp_rd = m_data[ix][o*8 +: 8];
            last_rd = exp_rd;
        end

        @(negedge clk);
        #2;
        mem_lat  = lat;
        cur_hit  = hit;
        rd_start = rd_count;
        base     = mon_q.size();
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = addr;
        bus.writedata = wdata;
        stall = 0;
        #1;
        while (bus.busywait !== 1'b0 && stall <= 300) begin
            stall++;
            @(negedge clk);
            #3;
        end
        obs_rd = bus.readdata;
        checks++;
        if (stall != exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d required %0d", name, stall, exp_stall);
        end
        if (!wr) begin
            checks++;
            if (obs_rd !== exp_rd) begin
                errors++;
                $display("FAIL %s readdata: got %02h required %02h", name, obs_rd, exp_rd);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() - base != e.size()) begin
            errors++;
            $display("FAIL %s mem_txn_count: got %0d required %0d", name, mon_q.size() - base, e.size());
        end else begin
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (mon_q[base + i] !== e[i]) begin
                    errors++;
                    $display("FAIL %s mem_txn[%0d]: got wr=%b addr=%02h data=%08h required wr=%b addr=%02h data=%08h",
                             name, i, mon_q[base+i].wr, mon_q[base+i].addr, mon_q[base+i].data,
                             e[i].wr, e[i].addr, e[i].data);
                end
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        #2;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.address = 8'($urandom_range(0, 255));
        #1;
        checks++;
        if (bus.busywait !== 1'b0 || bus.readdata !== last_rd) begin
            errors++;
            $display("FAIL idle_hold: busywait=%b readdata=%02h required 0 and %02h", bus.busywait, bus.readdata, last_rd);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[5] = 32'hDDCCBBAA;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
        model_reset();
        do_init = 1'b1;
        reset = 1'b0;
        bus.read = 1'b1;
        bus.write = 1'b0;
        bus.address = 8'h14;
        bus.writedata = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.busywait !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
            bus.readdata !== 8'h00 || state !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: busywait=%b mem_read=%b mem_write=%b readdata=%02h state=%0d required 0/0/0/00/IDLE",
                     bus.busywait, bus.mem_read, bus.mem_write, bus.readdata, state);
        end
        bus.read = 1'b0;
        #1;
        reset = 1'b1;
        do_init = 1'b0;
    endtask

    task automatic test_read_miss();
        access(1'b1, 1'b0, 8'h14, 8'h00, 5, "read_miss_14");
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 8'h16, 8'h3C, 5, "write_hit_16");
        access(1'b1, 1'b0, 8'h16, 8'h00, 5, "read_back_16");
        checks++;
        if (dut.u_lines.dirty_q[5] !== 1'b1) begin
            errors++;
            $display("FAIL dirty_line5: got %b required 1", dut.u_lines.dirty_q[5]);
        end
        go_idle();
    endtask

    task automatic test_dirty_evict();
        access(1'b1, 1'b0, 8'h34, 8'h00, 5, "evict_34");
        access(1'b1, 1'b0, 8'h35, 8'h00, 5, "hit_35");
    endtask

    task automatic test_read_write_both();
        access(1'b1, 1'b1, 8'h00, 8'h55, 5, "rw_both_00");
        access(1'b1, 1'b0, 8'h00, 8'h00, 5, "read_00");
        go_idle();
    endtask

    task automatic test_reset_mid_fetch();
        int waitc;
        waitc = 0;
        @(negedge clk);
        #2;
        mem_lat  = 5;
        cur_hit  = 1'b0;
        rd_start = rd_count;
        bus.read = 1'b1;
        bus.write = 1'b0;
        bus.address = 8'h14;
        while (bus.mem_read !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            #2;
            waitc++;
        end
        checks++;
        if (waitc >= 50) begin
            errors++;
            $display("FAIL fetch_start: mem_read never rose within %0d cycles", waitc);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0 || bus.readdata !== 8'h00 || state !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_fetch: mem_read=%b busywait=%b readdata=%02h state=%0d required 0/0/00/IDLE",
                     bus.mem_read, bus.busywait, bus.readdata, state);
        end
        model_reset();
        bus.read = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        access(1'b1, 1'b0, 8'h14, 8'h00, 5, "post_reset_14");
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            int         op;
            logic [7:0] a;
            op = $urandom_range(0, 2);
            a  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(op != 1, op != 0, a, 8'($urandom), $urandom_range(1, 4), "random");
            if ($urandom_range(0, 7) == 0) go_idle();
        end
        go_idle();
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem_arr[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL memory_image[%02h]: got %08h required %08h", i, mem_arr[i], ref_mem[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_read_write_both();
        test_reset_mid_fetch();
        test_random();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
